// File: rtl/ualfat_cmd_sequencer_if.sv
// Byte stream from the command sequencer to the SPI byte engine (valid/ready).
interface ualfat_cmd_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ualfat_cmd_sequencer.sv
// uALFAT command sequencer: reset pulse, boot wait, then one ROM script per button press.
// Optional BUTTON_DEBOUNCE_EN adds a DEB_CYCLES debounce filter; ROM image comes from ROM_INIT (byte i at bits [8*i +: 8]).
module ualfat_cmd_sequencer #(
  parameter int RST_PULSE = 100,
  parameter int BOOT_WAIT = 1000,
`ifdef BUTTON_DEBOUNCE_EN
  parameter int DEB_CYCLES = 50000,
`endif
  parameter int ROM_DEPTH = 64,
  parameter logic [ROM_DEPTH*8-1:0] ROM_INIT = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_button,
  ualfat_cmd_sequencer_if.master        tx,
  output logic                          o_ualfat_rst_n,
  output logic                          o_seq_busy,
  output logic                          o_boot_done
);

  localparam int CNT_MAX = (RST_PULSE > BOOT_WAIT) ? RST_PULSE : BOOT_WAIT;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int ADDR_W  = $clog2(ROM_DEPTH);
  localparam logic [CNT_W-1:0]  RST_TGT   = CNT_W'((RST_PULSE == 0) ? 0 : RST_PULSE - 1);
  localparam logic [CNT_W-1:0]  BOOT_TGT  = CNT_W'((BOOT_WAIT == 0) ? 0 : BOOT_WAIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_BOOT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_FETCH    = 3'd3,
    ST_CHECK    = 3'd4,
    ST_SEND     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_rom_q;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_urst_n, w_urst_n_nxt;
  logic              r_boot_done, w_boot_done_nxt;
  logic [1:0]        r_btn_sync;
  logic              r_btn_prev;
  logic              w_btn_level;
  logic              w_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_sync <= 2'b00;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], i_button};
      r_btn_prev <= w_btn_level;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_TGT = DEB_W'((DEB_CYCLES == 0) ? 0 : DEB_CYCLES - 1);
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb_level;

  // Level only follows the synchroniser after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else if (r_btn_sync[1] == r_deb_level) begin
      r_deb_cnt   <= '0;
    end else if (r_deb_cnt == DEB_TGT) begin
      r_deb_cnt   <= '0;
      r_deb_level <= r_btn_sync[1];
    end else begin
      r_deb_cnt   <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_btn_level = r_deb_level;
`else
  assign w_btn_level = r_btn_sync[1];
`endif

  assign w_press = w_btn_level & ~r_btn_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_RST_HOLD;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rom_q     <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_urst_n    <= 1'b0;
      r_boot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_urst_n    <= w_urst_n_nxt;
      r_boot_done <= w_boot_done_nxt;
      if (r_state == ST_FETCH) begin
        r_rom_q <= ROM_INIT[{r_addr, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_busy_nxt      = r_busy;
    w_urst_n_nxt    = r_urst_n;
    w_boot_done_nxt = r_boot_done;
    case (r_state)
      ST_RST_HOLD: begin
        if (r_cnt == RST_TGT) begin
          w_cnt_nxt    = '0;
          w_urst_n_nxt = 1'b1;
          w_state_nxt  = ST_BOOT;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
      end
      ST_BOOT: begin
        if (r_cnt == BOOT_TGT) begin
          w_cnt_nxt       = '0;
          w_boot_done_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_cnt_nxt       = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_press) begin
          w_busy_nxt  = 1'b1;
          w_addr_nxt  = '0;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_rom_q == 8'h00) begin
          w_state_nxt    = ST_DONE;
        end else begin
          w_tx_data_nxt  = r_rom_q;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Last ROM slot ends the script even without a terminator; the address never wraps.
        if (r_tx_valid && tx.tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (r_addr == ADDR_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_addr_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_RST_HOLD;
      end
    endcase
  end

  assign tx.tx_data     = r_tx_data;
  assign tx.tx_valid    = r_tx_valid;
  assign o_ualfat_rst_n = r_urst_n;
  assign o_seq_busy     = r_busy;
  assign o_boot_done    = r_boot_done;

endmodule
